// File: rtl/prm_oblgc_pkg.sv
// Shared types and constants for the obstacle-logic checker feeder.
// pack_voxel fixes the voxel-to-checker code bit order used by the checker generator.
package prm_oblgc_pkg;

   localparam int AXIS_W       = 5;
   localparam int OBLGC_CODE_W = 15;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      COUNT  = 3'd4,
      DONE   = 3'd5
   } oblgc_state_t;

   // Checker inputs {O..A} = {z, y, x}; A is x[0].
   function automatic logic [OBLGC_CODE_W-1:0] pack_voxel(
      input logic [AXIS_W-1:0] x,
      input logic [AXIS_W-1:0] y,
      input logic [AXIS_W-1:0] z
   );
      return {z, y, x};
   endfunction

endpackage

// File: rtl/prm_popcnt_word.sv
// Combinational population count of one bitmap word.
module prm_popcnt_word #(
   parameter int WORD_W = 32
) (
   input  logic [WORD_W-1:0]       word,
   output logic [$clog2(WORD_W):0] cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < WORD_W; i++) begin
         cnt = cnt + {{$clog2(WORD_W){1'b0}}, word[i]};
      end
   end

endmodule

// File: rtl/prm_oblgc_feeder.sv
// Feeds quantised voxels to the checker bank and collects a sticky blocked-edge bitmap per frame.
//
// state  | meaning
// IDLE   | waiting for frame_start
// CLEAR  | wipe bitmap and count for the new frame
// STREAM | accept voxels, one checker code per handshake
// DRAIN  | last code's mask lands in the bitmap
// COUNT  | popcount one bitmap word per cycle into blocked_cnt
// DONE   | one-cycle done pulse; frame_start here starts the next frame
module prm_oblgc_feeder
   import prm_oblgc_pkg::*;
#(
   parameter int N_EDGE = 256,
   parameter int WORD_W = 32
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              frame_start,
   input  logic                              pt_valid,
   output logic                              pt_ready,
   input  logic [AXIS_W-1:0]                 pt_x,
   input  logic [AXIS_W-1:0]                 pt_y,
   input  logic [AXIS_W-1:0]                 pt_z,
   input  logic                              pt_last,
   output logic [OBLGC_CODE_W-1:0]           chk_code,
   input  logic [N_EDGE-1:0]                 chk_mask,
   output logic                              busy,
   output logic                              done,
   output logic [$clog2(N_EDGE):0]           blocked_cnt,
   input  logic [$clog2(N_EDGE/WORD_W)-1:0]  rd_addr,
   output logic [WORD_W-1:0]                 rd_data
);

   localparam int N_WORD = N_EDGE / WORD_W;
   localparam int ADDR_W = $clog2(N_WORD);
   localparam int POP_W  = $clog2(WORD_W) + 1;
   localparam int CNT_W  = $clog2(N_EDGE) + 1;

   oblgc_state_t                   state;
   oblgc_state_t                   state_nxt;
   logic                           code_vld;
   logic [N_WORD-1:0][WORD_W-1:0]  bitmap;
   logic [ADDR_W-1:0]              word_ctr;
   logic [POP_W-1:0]               word_pop;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pt_ready  = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) state_nxt = CLEAR;
         end
         CLEAR: begin
            busy      = 1'b1;
            state_nxt = STREAM;
         end
         STREAM: begin
            busy     = 1'b1;
            pt_ready = 1'b1;
            if (pt_valid && pt_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            state_nxt = COUNT;
         end
         COUNT: begin
            busy = 1'b1;
            if (word_ctr == '0) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = frame_start ? CLEAR : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   prm_popcnt_word #(
      .WORD_W (WORD_W)
   ) u_popcnt (
      .word (bitmap[word_ctr]),
      .cnt  (word_pop)
   );

   // The mask seen one cycle after a handshake belongs to that voxel's code;
   // gaps leave chk_code stale but code_vld low, so nothing is accumulated.
   always_ff @(posedge CLK) begin
      if (RST) begin
         chk_code    <= '0;
         code_vld    <= 1'b0;
         bitmap      <= '0;
         blocked_cnt <= '0;
         word_ctr    <= '0;
         rd_data     <= '0;
      end else begin
         code_vld <= 1'b0;
         if (state == STREAM && pt_valid) begin
            chk_code <= pack_voxel(pt_x, pt_y, pt_z);
            code_vld <= 1'b1;
         end
         if (state == CLEAR) begin
            bitmap      <= '0;
            blocked_cnt <= '0;
            word_ctr    <= ADDR_W'(N_WORD - 1);
         end else if (code_vld) begin
            bitmap <= bitmap | chk_mask;
         end
         if (state == COUNT) begin
            blocked_cnt <= blocked_cnt + CNT_W'(word_pop);
            word_ctr    <= word_ctr - 1'b1;
         end
         rd_data <= bitmap[rd_addr];
      end
   end

endmodule
